time_set_sequencer: RTL and testbench
=====================================

Name: time_set_sequencer

Overview:
- Central controller for the alarm-clock timekeeping chain.
- Divides the system clock into a one-second tick and issues single-cycle enable pulses to the seconds, minutes, hours and day-of-week (0-6) load/up counters, with carry sequencing.
- Runs a MODE/INC button state machine that lets the user step hours, minutes and day directly.
- Counters are driven with Up=1; this block only supplies the Enable pulses and the seconds clear.

Parameters:
- TICK_DIV, 1000, number of Clk cycles per one-second tick (minimum 4).
- REPEAT_DLY, 2, number of ticks Inc_btn must be held before auto-repeat starts (used only with AUTO_REPEAT_EN).

Ports:
- Clk  input  1  system clock, rising edge.
- Clr  input  1  asynchronous active-low reset.
- Mode_btn  input  1  debounced, synchronous level; a rising edge advances the mode.
- Inc_btn  input  1  debounced, synchronous level; a rising edge increments the selected field.
- Sec_tc  input  1  seconds counter at 59.
- Min_tc  input  1  minutes counter at 59.
- Hour_tc  input  1  hours counter at 23.
- Sec_En  output  1  seconds counter enable pulse.
- Min_En  output  1  minutes counter enable pulse.
- Hour_En  output  1  hours counter enable pulse.
- Day_En  output  1  day counter (0-6) enable pulse.
- Sec_Clr  output  1  active-low seconds counter clear, one-cycle pulse.
- Mode  output  2  current state: 00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_DAY.
- Blink  output  1  display blink for the field being set.

Behaviour:
- Reset (Clr=0, asynchronous):
  - Mode=RUN, prescaler=0, button edge registers=0.
  - Sec_En, Min_En, Hour_En, Day_En, Blink = 0; Sec_Clr=1.
  - Reset takes effect mid-pulse or mid-set with no partial pulse completing.
- Prescaler:
  - 32-bit, counts 0..TICK_DIV-1 then wraps to 0.
  - tick is internal, high in the cycle where prescaler==TICK_DIV-1.
  - Runs in every state.
- Edge detect: registered previous value of each button; edge = btn & ~btn_q.
- All outputs are registered. A pulse appears in the cycle after its cause, is exactly 1 cycle wide, and never goes high on two consecutive cycles from the same cause.
- RUN, on tick:
  - Sec_En=1.
  - Min_En=Sec_tc.
  - Hour_En=Sec_tc&Min_tc.
  - Day_En=Sec_tc&Min_tc&Hour_tc.
  - tc inputs are sampled in the tick cycle.
- RUN: Blink=0. Inc edge is ignored.
- State transitions, Mode edge: RUN->SET_HOUR->SET_MIN->SET_DAY->RUN.
- Set states:
  - Tick-driven enables are suppressed; there is no carry propagation.
  - Inc edge pulses only the selected enable: SET_HOUR->Hour_En, SET_MIN->Min_En, SET_DAY->Day_En. Wrap is handled by the counter itself.
- Blink:
  - Toggles on every tick in set states.
  - Forced to 0 on entry to RUN.
  - Forced to 1 on entry to SET_HOUR.
- Exit SET_DAY->RUN:
  - Sec_Clr=0 for exactly the next cycle.
  - Prescaler reloaded to 0, so the first Sec_En comes TICK_DIV cycles after the Sec_Clr pulse.
- Simultaneous events:
  - Mode and Inc edges in the same cycle: Mode wins, Inc is dropped.
  - Tick and Mode edge in the same RUN cycle: the tick pulses are still issued and the state advances.
- Button held: only one action per rising edge.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - In set states, a hold counter counts ticks while Inc_btn stays high.
  - Once REPEAT_DLY ticks have elapsed, one additional increment pulse is issued on every subsequent tick until release.
  - Hold counter clears on release, on a Mode edge, and on reset.
- Undefined: increments occur on Inc edge only; no hold counter is synthesised.

Test Plan:
- TICK_DIV=4, reset released, tc inputs low -> Sec_En pulses 1 cycle every 4 cycles; Min_En, Hour_En, Day_En stay 0; Mode=00.
- RUN, Sec_tc=Min_tc=Hour_tc=1 at a tick -> next cycle Sec_En=Min_En=Hour_En=Day_En=1 for exactly 1 cycle.
- Mode edge x1, then Inc edge x3 -> Mode=01, three single-cycle Hour_En pulses; no Sec_En while in set state; Blink toggles each tick.
- Mode edges x4 from RUN -> Mode sequence 01,10,11,00; Sec_Clr=0 for 1 cycle on return to RUN; first Sec_En 4 cycles later.
- Mode and Inc rising together in SET_MIN -> Mode=11, no Min_En; Clr asserted mid-SET_DAY -> Mode=00 and all enables 0 immediately (asynchronous).
- AUTO_REPEAT_EN, REPEAT_DLY=2, SET_MIN, Inc held 5 ticks -> 1 edge pulse plus repeat pulses on ticks 3, 4 and 5 (4 Min_En total); release stops the pulses.

Source files
------------

// File: rtl/time_set_sequencer_if.sv
// Button, terminal-count and counter-enable bundle between the alarm-clock
// controller (slave side) and its environment (master side).
interface time_set_sequencer_if;
  logic       Mode_btn;
  logic       Inc_btn;
  logic       Sec_tc;
  logic       Min_tc;
  logic       Hour_tc;
  logic       Sec_En;
  logic       Min_En;
  logic       Hour_En;
  logic       Day_En;
  logic       Sec_Clr;
  logic [1:0] Mode;
  logic       Blink;

  modport master (
    output Mode_btn, Inc_btn, Sec_tc, Min_tc, Hour_tc,
    input  Sec_En, Min_En, Hour_En, Day_En, Sec_Clr, Mode, Blink
  );

  modport slave (
    input  Mode_btn, Inc_btn, Sec_tc, Min_tc, Hour_tc,
    output Sec_En, Min_En, Hour_En, Day_En, Sec_Clr, Mode, Blink
  );
endinterface

// File: rtl/time_set_sequencer.sv
// Alarm-clock controller: one-second prescaler, carry-sequenced counter enables, MODE/INC set FSM.
// Latency: every output is registered, one cycle after its cause. Backpressure: none, pulses are fire-and-forget.
// AUTO_REPEAT_EN adds Inc hold-to-repeat in set states after REPEAT_DLY ticks.
module time_set_sequencer #(
  parameter int TICK_DIV   = 1000,
  parameter int REPEAT_DLY = 2
) (
  input logic                 Clk,
  input logic                 Clr,
  time_set_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_DAY  = 2'b11
  } mode_t;

  mode_t       state;
  logic [31:0] presc;
  logic        tick;
  logic        mode_q;
  logic        inc_q;
  logic        mode_edge;
  logic        inc_edge;
  logic        inc_act;
  logic        rpt;
  logic        sec_en;
  logic        min_en;
  logic        hour_en;
  logic        day_en;
  logic        sec_clr_n;
  logic        blink;

  assign tick      = (presc == 32'(TICK_DIV - 1));
  assign mode_edge = bus.Mode_btn & ~mode_q;
  assign inc_edge  = bus.Inc_btn & ~inc_q;
  assign inc_act   = inc_edge | rpt;

`ifdef AUTO_REPEAT_EN
  localparam int HOLD_W = (REPEAT_DLY < 1) ? 1 : $clog2(REPEAT_DLY + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;

  assign hold_done = (hold_cnt == HOLD_W'(REPEAT_DLY));
  assign rpt       = tick & (state != RUN) & bus.Inc_btn & hold_done;

  // Saturates at REPEAT_DLY; from then on every tick while held repeats.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      hold_cnt <= '0;
    end else if ((state == RUN) || !bus.Inc_btn || mode_edge) begin
      hold_cnt <= '0;
    end else if (tick && !hold_done) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  logic unused_repeat_dly;
  assign unused_repeat_dly = ^REPEAT_DLY;
  assign rpt               = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state     <= RUN;
      presc     <= '0;
      mode_q    <= 1'b0;
      inc_q     <= 1'b0;
      sec_en    <= 1'b0;
      min_en    <= 1'b0;
      hour_en   <= 1'b0;
      day_en    <= 1'b0;
      sec_clr_n <= 1'b1;
      blink     <= 1'b0;
    end else begin
      mode_q    <= bus.Mode_btn;
      inc_q     <= bus.Inc_btn;
      presc     <= tick ? '0 : presc + 32'd1;
      sec_en    <= 1'b0;
      min_en    <= 1'b0;
      hour_en   <= 1'b0;
      day_en    <= 1'b0;
      sec_clr_n <= 1'b1;

      if (state == RUN) begin
        if (tick) begin
          sec_en  <= 1'b1;
          min_en  <= bus.Sec_tc;
          hour_en <= bus.Sec_tc & bus.Min_tc;
          day_en  <= bus.Sec_tc & bus.Min_tc & bus.Hour_tc;
        end
      end else begin
        if (tick) blink <= ~blink;
        // A Mode edge in the same cycle swallows the increment.
        if (inc_act && !mode_edge) begin
          case (state)
            SET_HOUR: hour_en <= 1'b1;
            SET_MIN:  min_en  <= 1'b1;
            SET_DAY:  day_en  <= 1'b1;
            default:  ;
          endcase
        end
      end

      if (mode_edge) begin
        case (state)
          RUN: begin
            state <= SET_HOUR;
            blink <= 1'b1;
          end
          SET_HOUR: state <= SET_MIN;
          SET_MIN:  state <= SET_DAY;
          SET_DAY: begin
            // Restart the second cleanly: seconds cleared, prescaler phase reset.
            state     <= RUN;
            blink     <= 1'b0;
            sec_clr_n <= 1'b0;
            presc     <= '0;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  assign bus.Sec_En  = sec_en;
  assign bus.Min_En  = min_en;
  assign bus.Hour_En = hour_en;
  assign bus.Day_En  = day_en;
  assign bus.Sec_Clr = sec_clr_n;
  assign bus.Mode    = state;
  assign bus.Blink   = blink;

endmodule

// File: tb/tb_time_set_sequencer.sv
// Randomized and directed bench for time_set_sequencer against a cycle-level behavioural model.
module tb_time_set_sequencer;
  localparam int TICK_DIV   = 4;
  localparam int REPEAT_DLY = 2;

  logic Clk = 1'b0;
  logic Clr;

  time_set_sequencer_if bus ();

  time_set_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .REPEAT_DLY(REPEAT_DLY)
  ) dut (
    .Clk(Clk),
    .Clr(Clr),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Model: elapsed cycles since the last prescaler restart, mode number 0..3, etc.
  int m_age;
  int m_mode;
  bit m_blink;
  bit m_pm;
  bit m_pi;
  int m_held;
  bit e_sec, e_min, e_hour, e_day, e_clr;
  int n_sec, n_min, n_hour, n_day;

  task automatic model_reset();
    m_age = 0; m_mode = 0; m_blink = 0; m_pm = 0; m_pi = 0; m_held = 0;
    e_sec = 0; e_min = 0; e_hour = 0; e_day = 0; e_clr = 1;
  endtask

  task automatic clear_tally();
    n_sec = 0; n_min = 0; n_hour = 0; n_day = 0;
  endtask

  // Called at a negedge: drive inputs, predict, advance one cycle, compare.
  task automatic step(input bit mb, input bit ib, input bit stc, input bit mtc, input bit htc);
    bit me, ie, tick, inc;
    bus.Mode_btn = mb; bus.Inc_btn = ib;
    bus.Sec_tc = stc; bus.Min_tc = mtc; bus.Hour_tc = htc;
    me = mb && !m_pm;
    ie = ib && !m_pi;
    m_pm = mb; m_pi = ib;
    tick = (m_age % TICK_DIV) == (TICK_DIV - 1);
    e_sec = 0; e_min = 0; e_hour = 0; e_day = 0; e_clr = 1;
    inc = ie;
`ifdef AUTO_REPEAT_EN
    if (m_mode != 0 && ib && !me) begin
      if (tick) begin
        if (m_held >= REPEAT_DLY) inc = 1;
        m_held++;
      end
    end else begin
      m_held = 0;
    end
`endif
    if (m_mode == 0) begin
      if (tick) begin
        e_sec = 1;
        e_min = stc;
        e_hour = stc && mtc;
        e_day = stc && mtc && htc;
      end
    end else begin
      if (tick) m_blink = !m_blink;
      if (inc && !me) begin
        if (m_mode == 1) e_hour = 1;
        if (m_mode == 2) e_min = 1;
        if (m_mode == 3) e_day = 1;
      end
    end
    m_age++;
    if (me) begin
      m_mode = (m_mode + 1) % 4;
      if (m_mode == 1) m_blink = 1;
      if (m_mode == 0) begin
        m_blink = 0; e_clr = 0; m_age = 0;
      end
    end
    @(negedge Clk);
    check("Sec_En", bus.Sec_En, e_sec);
    check("Min_En", bus.Min_En, e_min);
    check("Hour_En", bus.Hour_En, e_hour);
    check("Day_En", bus.Day_En, e_day);
    check("Sec_Clr", bus.Sec_Clr, e_clr);
    check("Mode", bus.Mode, m_mode);
    check("Blink", bus.Blink, m_blink);
    n_sec += int'(bus.Sec_En); n_min += int'(bus.Min_En);
    n_hour += int'(bus.Hour_En); n_day += int'(bus.Day_En);
  endtask

  task automatic press_mode();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    int gap;
    bit rmb, rib;
    Clr = 1'b0;
    bus.Mode_btn = 0; bus.Inc_btn = 0; bus.Sec_tc = 0; bus.Min_tc = 0; bus.Hour_tc = 0;
    repeat (3) @(negedge Clk);
    check("rst_mode", bus.Mode, 0);
    check("rst_sec_en", bus.Sec_En, 0);
    check("rst_day_en", bus.Day_En, 0);
    check("rst_sec_clr", bus.Sec_Clr, 1);
    check("rst_blink", bus.Blink, 0);
    Clr = 1'b1;
    model_reset();

    // Free-running RUN with tc low.
    clear_tally();
    repeat (16) step(0, 0, 0, 0, 0);
    check("run_sec_count", n_sec, 4);
    check("run_min_count", n_min, 0);

    // Full carry chain on one tick.
    clear_tally();
    repeat (TICK_DIV) step(0, 0, 1, 1, 1);
    check("carry_min", n_min, 1);
    check("carry_hour", n_hour, 1);
    check("carry_day", n_day, 1);

    // SET_HOUR with three increments.
    step(1, 0, 0, 0, 0);
    clear_tally();
    step(0, 0, 0, 0, 0);
    repeat (3) begin
      step(0, 1, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
    end
    check("set_hour_incs", n_hour, 3);
    check("set_hour_no_sec", n_sec, 0);

    // Walk back to RUN and time the first Sec_En after the clear.
    press_mode();
    press_mode();
    step(1, 0, 0, 0, 0);
    check("exit_sec_clr", bus.Sec_Clr, 0);
    gap = 0;
    do begin
      step(0, 0, 0, 0, 0);
      gap++;
    end while (!bus.Sec_En && gap < 20);
    check("first_sec_gap", gap, TICK_DIV);

    // Mode and Inc together in SET_MIN, then async reset mid-pulse in SET_DAY.
    press_mode();
    press_mode();
    clear_tally();
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("mode_wins_min", n_min, 0);
    check("mode_wins_state", bus.Mode, 3);
    step(0, 1, 0, 0, 0);
    check("day_pulse_pre_rst", bus.Day_En, 1);
    #2 Clr = 1'b0;
    #1;
    check("arst_mode", bus.Mode, 0);
    check("arst_day_en", bus.Day_En, 0);
    check("arst_blink", bus.Blink, 0);
    check("arst_sec_clr", bus.Sec_Clr, 1);
    bus.Mode_btn = 0; bus.Inc_btn = 0;
    @(negedge Clk);
    Clr = 1'b1;
    model_reset();

    // Inc held for five ticks in SET_MIN.
    press_mode();
    press_mode();
    gap = 0;
    while ((m_age % TICK_DIV) != 0 && gap < 20) begin
      step(0, 0, 0, 0, 0);
      gap++;
    end
    clear_tally();
    repeat (5 * TICK_DIV) step(0, 1, 0, 0, 0);
    repeat (3 * TICK_DIV) step(0, 0, 0, 0, 0);
`ifdef AUTO_REPEAT_EN
    check("hold_min_count", n_min, 4);
`else
    check("hold_min_count", n_min, 1);
`endif

    // Random buttons and terminal counts.
    rmb = 0; rib = 0;
    repeat (3000) begin
      if ($urandom_range(15) == 0) rmb = !rmb;
      if ($urandom_range(5) == 0) rib = !rib;
      step(rmb, rib, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
